note_tone_gen: RTL and testbench
================================

NOTE_TONE_GEN -- requirements
Module: note_tone_gen

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz used to derive tone half-periods.
REQ-002 Parameter GAP_CYCLES, default 2_000_000, silent articulation cycles inserted before each new tone; legal range 1..2^24-1.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 mute  input  1  level; forces silence while high.
REQ-006 note  input  5  note code from the sequencer: 0 rest, 1-7 low do-si, 8-14 middle do-si, 15-21 high do-si, 22-31 rest.
REQ-007 buzzer  output  1  registered square-wave drive to the piezo.
REQ-008 playing  output  1  registered, high while a tone is being generated.

Function
REQ-009 Block SHALL register note into note_q every cycle; a "change" is note != note_q at a rising edge.
REQ-010 Frequencies (Hz) SHALL be: middle 262,294,330,349,392,440,494; low 131,147,165,175,196,220,247; high 523,587,659,698,784,880,988.
REQ-011 Half-period HP SHALL equal round(CLK_HZ / (2*f)), computed at elaboration; counter width 24 bits.
REQ-012 States SHALL be SILENT, GAP, TONE.
REQ-013 SILENT: buzzer 0, playing 0; on change to a valid code (1-21) with mute low -> GAP, cnt 0.
REQ-014 GAP: buzzer 0, playing 0; cnt increments; at cnt == GAP_CYCLES-1 -> TONE, cnt 0, buzzer 0.
REQ-015 TONE: playing 1; cnt increments; at cnt == HP-1 buzzer toggles and cnt returns to 0.
REQ-016 Any change to a valid code in GAP or TONE SHALL restart: GAP, cnt 0, buzzer 0 at that edge (phase never carried over).
REQ-017 Change to a rest code (0, 22-31) SHALL go to SILENT with buzzer 0, playing 0 at that edge.
REQ-018 Unchanged note SHALL sustain TONE indefinitely without gaps (repeated codes are one held note).
REQ-019 mute high SHALL force SILENT, buzzer 0, playing 0 at the next edge, overriding note changes.
REQ-020 mute falling with note_q valid SHALL be treated as a change: GAP then TONE.
REQ-021 Output latency: buzzer/playing respond one edge after the input that causes them.

Reset
REQ-022 rst high at an edge SHALL set state SILENT, cnt 0, note_q 0, buzzer 0, playing 0; rst overrides mute and note.
REQ-023 After rst falls, a valid held note SHALL be seen as a change (note_q 0) and enter GAP.
REQ-024 rst mid-GAP or mid-TONE SHALL abort immediately with no residual toggle.

Structure
REQ-025 Shared package note_pkg SHALL hold the state enum, NOTE_REST code, code ranges, and the frequency table.
REQ-026 Sub-module note_period_rom SHALL map 5-bit code to 24-bit HP (0 for rest codes), parameterised by CLK_HZ.

Verification (CLK_HZ=1_000_000, GAP_CYCLES=100)
REQ-027 rst high 3 cycles, note=13 -> buzzer 0, playing 0 throughout; after release 100 gap cycles then playing 1.
REQ-028 note 0->13 -> 100 cycles silent, then playing 1, buzzer toggles every 1136 cycles (440 Hz).
REQ-029 note 13->8 while buzzer high -> buzzer 0 next edge, 100 gap cycles, then toggles every 1908 cycles.
REQ-030 note 13->25 -> buzzer 0, playing 0 next edge and stays low.
REQ-031 mute high mid-tone -> silence next edge; mute low with note 13 -> 100 gap cycles then 1136-cycle toggling from buzzer 0.
REQ-032 note held at 10 for 10000 cycles -> no gap after initial one; toggle spacing constant 1515 cycles.

Source files
------------

// File: rtl/note_pkg.sv
// Shared definitions for the note tone generator: FSM states, note code
// ranges and the musical frequency table (low, middle, high octaves).
package note_pkg;

    typedef enum logic [1:0] {
        SILENT = 2'd0,
        GAP    = 2'd1,
        TONE   = 2'd2
    } state_t;

    localparam logic [4:0] NOTE_REST  = 5'd0;
    localparam logic [4:0] NOTE_FIRST = 5'd1;
    localparam logic [4:0] NOTE_LAST  = 5'd21;
    localparam int         NUM_NOTES  = 21;
    localparam int         CNT_W      = 24;

    // Index 0 corresponds to code 1 (low do); index 20 to code 21 (high si).
    localparam int unsigned FREQ_TABLE [NUM_NOTES] = '{
        131, 147, 165, 175, 196, 220, 247,
        262, 294, 330, 349, 392, 440, 494,
        523, 587, 659, 698, 784, 880, 988
    };

    // Codes outside 1..21 (including NOTE_REST) are rests.
    function automatic logic is_tone_code(input logic [4:0] code);
        return (code >= NOTE_FIRST) && (code <= NOTE_LAST);
    endfunction

endpackage

// File: rtl/note_period_rom.sv
// Maps a 5-bit note code to the square-wave half-period in clock cycles,
// round(CLK_HZ / (2*f)). Rest codes map to 0. Table is fixed at elaboration.
module note_period_rom
    import note_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic [4:0]       code,
    output logic [CNT_W-1:0] hp
);

    logic [CNT_W-1:0] hp_table [NUM_NOTES];

    // Adding f before dividing by 2f rounds to nearest.
    for (genvar i = 0; i < NUM_NOTES; i++) begin : g_hp
        assign hp_table[i] = CNT_W'((CLK_HZ + FREQ_TABLE[i]) / (2 * FREQ_TABLE[i]));
    end

    // Table lookup; rests produce 0.
    always_comb begin
        hp = '0;
        if (is_tone_code(code)) begin
            hp = hp_table[code - 5'd1];
        end
    end

endmodule

// File: rtl/note_tone_gen.sv
// Piezo tone generator: each new note gets a silent articulation gap, then a
// square wave at the note's pitch. Held codes sustain; rests and mute silence.
module note_tone_gen
    import note_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned GAP_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mute,
    input  logic [4:0] note,
    output logic       buzzer,
    output logic       playing
);

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [4:0]       note_q;
    logic             mute_q;
    logic             buzzer_nxt, playing_nxt;
    logic [CNT_W-1:0] hp;
    logic             change, restart, to_rest;

    // Half-period follows the registered note; in TONE it equals the live note.
    note_period_rom #(.CLK_HZ(CLK_HZ)) u_rom (
        .code (note_q),
        .hp   (hp)
    );

    // A mute release with a valid note counts as a fresh attack.
    assign change  = (note != note_q);
    assign restart = is_tone_code(note) && (change || (mute_q && !mute));
    assign to_rest = change && !is_tone_code(note);

    // State, counter, history and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SILENT;
            cnt     <= '0;
            note_q  <= NOTE_REST;
            mute_q  <= 1'b0;
            buzzer  <= 1'b0;
            playing <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            note_q  <= note;
            mute_q  <= mute;
            buzzer  <= buzzer_nxt;
            playing <= playing_nxt;
        end
    end

    // Next-state logic: mute beats everything, then restart, then rest, then timing.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        buzzer_nxt  = buzzer;
        playing_nxt = playing;
        if (mute || to_rest) begin
            state_nxt   = SILENT;
            cnt_nxt     = '0;
            buzzer_nxt  = 1'b0;
            playing_nxt = 1'b0;
        end else if (restart) begin
            state_nxt   = GAP;
            cnt_nxt     = '0;
            buzzer_nxt  = 1'b0;
            playing_nxt = 1'b0;
        end else begin
            unique case (state)
                SILENT: begin
                    cnt_nxt     = '0;
                    buzzer_nxt  = 1'b0;
                    playing_nxt = 1'b0;
                end
                GAP: begin
                    buzzer_nxt  = 1'b0;
                    playing_nxt = 1'b0;
                    if (cnt == GAP_LAST) begin
                        state_nxt   = TONE;
                        cnt_nxt     = '0;
                        playing_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                TONE: begin
                    playing_nxt = 1'b1;
                    if (cnt == hp - 1'b1) begin
                        buzzer_nxt = ~buzzer;
                        cnt_nxt    = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt   = SILENT;
                    cnt_nxt     = '0;
                    buzzer_nxt  = 1'b0;
                    playing_nxt = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_tone_gen.sv
// Scoreboard bench for note_tone_gen at CLK_HZ=1 MHz, GAP_CYCLES=100.
// Stimulus pushes the expected output transitions (edge number, buzzer,
// playing); a monitor pops and compares each transition the DUT produces.
module tb_note_tone_gen;

    localparam int GAP    = 100;
    localparam int HP_LA  = 1136;  // 440 Hz
    localparam int HP_DO  = 1908;  // 262 Hz
    localparam int HP_MI  = 1515;  // 330 Hz

    typedef struct {
        int   cyc;
        logic buz;
        logic play;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       mute;
    logic [4:0] note;
    logic       buzzer;
    logic       playing;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    logic prev_buz, prev_play;
    ev_t  exp_q[$];

    note_tone_gen #(.CLK_HZ(1_000_000), .GAP_CYCLES(GAP)) dut (
        .clk     (clk),
        .rst     (rst),
        .mute    (mute),
        .note    (note),
        .buzzer  (buzzer),
        .playing (playing)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every output transition must match the next expected event;
    // an expected event whose edge has passed unobserved is reported late.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL late_event expected edge %0d buz %0b play %0b, not observed by edge %0d",
                         exp_q[0].cyc, exp_q[0].buz, exp_q[0].play, cyc);
                void'(exp_q.pop_front());
            end
            if (buzzer !== prev_buz || playing !== prev_play) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event edge %0d buz %0b play %0b, required no change",
                             cyc, buzzer, playing);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.buz !== buzzer || e.play !== playing) begin
                        errors++;
                        $display("FAIL event got edge %0d buz %0b play %0b, required edge %0d buz %0b play %0b",
                                 cyc, buzzer, playing, e.cyc, e.buz, e.play);
                    end
                end
                prev_buz  = buzzer;
                prev_play = playing;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) step();
    endtask

    task automatic push(input int c, input logic b, input logic p);
        ev_t e;
        e.cyc  = c;
        e.buz  = b;
        e.play = p;
        exp_q.push_back(e);
    endtask

    // n buzzer toggles, hp edges apart, starting from buzzer 0 at tone start.
    task automatic push_toggles(input int start, input int hp, input int n);
        logic b;
        b = 1'b0;
        for (int k = 1; k <= n; k++) begin
            b = ~b;
            push(start + k * hp, b, 1'b1);
        end
    endtask

    initial begin
        int t;
        rst  = 1'b1;
        mute = 1'b0;
        note = 5'd13;

        // Reset held 3 edges with a valid note: outputs stay low.
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (buzzer !== 1'b0 || playing !== 1'b0) begin
                errors++;
                $display("FAIL reset_state buz %0b play %0b, required buz 0 play 0", buzzer, playing);
            end
        end
        prev_buz  = buzzer;
        prev_play = playing;
        mon_en    = 1'b1;

        // Release: held note 13 is a change -> 100 gap edges, then 440 Hz.
        rst = 1'b0;
        t = cyc;
        push(t + 1 + GAP, 1'b0, 1'b1);
        push_toggles(t + 1 + GAP, HP_LA, 3);
        wait_until(t + 1 + GAP + 3 * HP_LA + 10);

        // 13 -> 8 while buzzer high: silence next edge, gap, then 262 Hz.
        t = cyc;
        note = 5'd8;
        push(t + 1, 1'b0, 1'b0);
        push(t + 1 + GAP, 1'b0, 1'b1);
        push_toggles(t + 1 + GAP, HP_DO, 2);
        wait_until(t + 1 + GAP + 2 * HP_DO + 5);

        // 8 -> 13 with buzzer low: playing drops, gap, 440 Hz again.
        t = cyc;
        note = 5'd13;
        push(t + 1, 1'b0, 1'b0);
        push(t + 1 + GAP, 1'b0, 1'b1);
        push_toggles(t + 1 + GAP, HP_LA, 1);
        wait_until(t + 1 + GAP + HP_LA + 20);

        // 13 -> 25 (rest code) with buzzer high: silent next edge and stays so.
        t = cyc;
        note = 5'd25;
        push(t + 1, 1'b0, 1'b0);
        wait_until(t + 3000);

        // Rest -> 13 (already silent, so first event is playing rising).
        t = cyc;
        note = 5'd13;
        push(t + 1 + GAP, 1'b0, 1'b1);
        push_toggles(t + 1 + GAP, HP_LA, 1);
        wait_until(t + 1 + GAP + HP_LA + 50);

        // Mute mid-tone: silence next edge; note changes while muted are ignored.
        t = cyc;
        mute = 1'b1;
        push(t + 1, 1'b0, 1'b0);
        wait_until(t + 200);
        note = 5'd8;
        wait_until(t + 400);
        note = 5'd13;
        wait_until(t + 600);

        // Mute release with note 13 held: gap, then 440 Hz from buzzer 0.
        t = cyc;
        mute = 1'b0;
        push(t + 1 + GAP, 1'b0, 1'b1);
        push_toggles(t + 1 + GAP, HP_LA, 2);
        wait_until(t + 1 + GAP + 2 * HP_LA + 10);

        // Note 10 held > 10000 edges: one gap, constant 1515-edge spacing.
        t = cyc;
        note = 5'd10;
        push(t + 1, 1'b0, 1'b0);
        push(t + 1 + GAP, 1'b0, 1'b1);
        push_toggles(t + 1 + GAP, HP_MI, 7);
        wait_until(t + 1 + GAP + 7 * HP_MI + 10);

        // Reset mid-tone with buzzer high: immediate silence, no residual toggle.
        t = cyc;
        rst = 1'b1;
        push(t + 1, 1'b0, 1'b0);
        wait_until(t + 5);
        t = cyc;
        rst = 1'b0;
        push(t + 1 + GAP, 1'b0, 1'b1);
        wait_until(t + 1 + GAP + 50);

        // Reset mid-gap: abort before the tone can start.
        t = cyc;
        note = 5'd8;
        push(t + 1, 1'b0, 1'b0);
        wait_until(t + 50);
        rst = 1'b1;
        wait_until(t + 55);
        rst  = 1'b0;
        note = 5'd0;
        wait_until(t + 400);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got %0d outstanding, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
